// File: rtl/image_ingest.sv
// image_ingest: unpacks a start_main-framed stream of packed pixel words into a buffer, launches the core, returns its label.
// Optional protocol-violation tracking on proto_err when INGEST_PROTO_CHECK_EN is defined.
module image_ingest #(
  parameter int M     = 784,
  parameter int PIX_W = 8,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_main,
  input  logic [31:0]      image_in,
  input  logic             valid_image,
  output logic             ready,
  output logic             start_core_img,
  input  logic [AW-1:0]    pix_addr,
  output logic [PIX_W-1:0] pix_data,
  input  logic             core_done,
  input  logic [7:0]       core_label,
  output logic [7:0]       image_label,
  output logic             valid_all,
  output logic             proto_err
);
  localparam int WW = $clog2(M/4);
  localparam logic [WW-1:0] LAST = WW'(M/4 - 1);
  localparam logic [AW:0] MEND = (AW+1)'(M);
  typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, RUN, DONE} state_t;
  state_t state;
  logic [WW-1:0] wcnt;
  logic [PIX_W-1:0] mem [M];
  logic we;
  logic [AW-1:0] base;
  assign we = state == LOAD && valid_image && !start_main;
  assign base = AW'({wcnt, 2'b00});
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wcnt <= '0;
      ready <= 1'b1;
      start_core_img <= 1'b0;
      valid_all <= 1'b0;
      image_label <= '0;
    end else begin
      start_core_img <= 1'b0;
      valid_all <= 1'b0;
      case (state)
        IDLE: if (start_main) begin
          state <= LOAD;
          wcnt <= '0;
          ready <= 1'b0;
        end
        LOAD: if (start_main) wcnt <= '0;
        else if (valid_image) begin
          wcnt <= wcnt == LAST ? '0 : wcnt + WW'(1);
          if (wcnt == LAST) begin
            state <= LAUNCH;
            start_core_img <= 1'b1;
          end
        end
        LAUNCH: state <= RUN;
        RUN: if (core_done) begin
          image_label <= core_label;
          valid_all <= 1'b1;
          state <= DONE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end
  // Buffer is deliberately not reset so contents survive across images and resets.
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < 4; i++) mem[base + AW'(i)] <= image_in[(3-i)*PIX_W +: PIX_W];
  always_ff @(posedge clk or negedge rst)
    if (!rst) pix_data <= '0;
    else pix_data <= {1'b0, pix_addr} < MEND ? mem[pix_addr] : '0;
`ifdef INGEST_PROTO_CHECK_EN
  logic stray;
  assign stray = (start_main && state != IDLE) ||
                 (valid_image && (state == IDLE ? !start_main : state != LOAD)) ||
                 (core_done && state != RUN);
  always_ff @(posedge clk or negedge rst)
    if (!rst) proto_err <= 1'b0;
    else if (stray) proto_err <= 1'b1;
`else
  assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_image_ingest.sv
// tb_image_ingest: scoreboard bench for image_ingest covering load, gaps, restart, stray inputs and async reset.
`timescale 1ns/1ps
module tb_image_ingest;
  localparam int M = 784;
  localparam int AW = 10;
  logic clk = 0, rst = 0, start_main = 0, valid_image = 0, core_done = 0;
  logic [31:0] image_in = 0;
  logic [AW-1:0] pix_addr = 0;
  logic [7:0] core_label = 0;
  logic ready, start_core_img, valid_all, proto_err;
  logic [7:0] pix_data, image_label;
  int tests = 0, fails = 0, sc_cnt = 0, va_cnt = 0;
  logic exp_perr = 0;
  logic [7:0] last_label = 0;
  logic [7:0] model [1024];
  logic [7:0] pq [$];
  logic [7:0] lq [$];

  image_ingest #(.M(M), .PIX_W(8), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start_main(start_main), .image_in(image_in),
    .valid_image(valid_image), .ready(ready), .start_core_img(start_core_img),
    .pix_addr(pix_addr), .pix_data(pix_data), .core_done(core_done),
    .core_label(core_label), .image_label(image_label), .valid_all(valid_all),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_core_img) sc_cnt++;
    if (valid_all) va_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input int mode, input int i);
    logic [31:0] w;
    for (int k = 0; k < 4; k++)
      w[31-8*k -: 8] = mode == 1 ? 8'hAA : mode == 2 ? 8'((4*i+k) ^ 'h5A) : 8'(4*i+k);
    return w;
  endfunction

  task check_reset_outs(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_sc"}, start_core_img, 0);
    chk({tag, "_pix"}, pix_data, 0);
    chk({tag, "_label"}, image_label, 0);
    chk({tag, "_va"}, valid_all, 0);
    chk({tag, "_perr"}, proto_err, 0);
  endtask

  task load(input int mode, input int gap, input int restart_at, input int abort_at);
    int i, cyc, sc0, wm;
    sc0 = sc_cnt;
    chk("ready_idle", ready, 1);
    start_main = 1;
    step;
    start_main = 0;
    chk("ready_drop", ready, 0);
    i = 0;
    cyc = 0;
    while (i < M/4) begin
      if (restart_at > 0 && i == restart_at) begin
        start_main = 1;
        valid_image = 1;
        image_in = 32'hDEADBEEF;
        step;
        start_main = 0;
        valid_image = 0;
        restart_at = 0;
        i = 0;
`ifdef INGEST_PROTO_CHECK_EN
        exp_perr = 1;
`endif
        continue;
      end
      if (abort_at > 0 && i == abort_at) begin
        valid_image = 0;
        rst = 0;
        #2;
        check_reset_outs("rst_async");
        step;
        step;
        check_reset_outs("rst_hold");
        rst = 1;
        exp_perr = 0;
        last_label = 0;
        step;
        chk("rst_ready", ready, 1);
        return;
      end
      wm = restart_at > 0 ? 0 : mode;
      if (gap != 0 && cyc % 3 == 2) valid_image = 0;
      else begin
        valid_image = 1;
        image_in = word_of(wm, i);
        for (int k = 0; k < 4; k++) model[4*i+k] = image_in[31-8*k -: 8];
        i++;
      end
      cyc++;
      step;
    end
    valid_image = 0;
    chk("launch", start_core_img, 1);
    step;
    chk("launch_1cyc", start_core_img, 0);
    chk("sc_count", sc_cnt, sc0 + 1);
  endtask

  task sweep;
    pq.delete();
    pix_addr = 0;
    pq.push_back(model[0]);
    for (int a = 1; a <= 1024; a++) begin
      step;
      chk("pix", pix_data, pq.pop_front());
      if (a < 1024) begin
        pix_addr = AW'(a);
        pq.push_back(model[a]);
      end
    end
  endtask

  task finish_image(input logic [7:0] lbl);
    core_done = 1;
    core_label = lbl;
    lq.push_back(lbl);
    step;
    core_done = 0;
    chk("valid_all", valid_all, 1);
    chk("ready_done", ready, 0);
    chk("label", image_label, lq.pop_front());
    last_label = lbl;
    step;
    chk("valid_all_1cyc", valid_all, 0);
    chk("ready_back", ready, 1);
    chk("label_hold", image_label, last_label);
  endtask

  initial begin
    int va0;
    for (int a = 0; a < 1024; a++) model[a] = 0;
    step;
    step;
    check_reset_outs("reset");
    rst = 1;
    step;
    chk("ready_after_rst", ready, 1);
    load(0, 0, 0, 0);
    sweep;
    chk("perr_nominal", proto_err, exp_perr);
    finish_image(8'h07);
    va0 = va_cnt;
    for (int n = 0; n < 100; n++) begin
      load(0, 0, 0, 0);
      finish_image(8'(n));
    end
    chk("va_count", va_cnt, va0 + 100);
    valid_image = 1;
    image_in = 32'h0BADF00D;
    step;
    step;
    valid_image = 0;
    core_done = 1;
    core_label = 8'h55;
    step;
    core_done = 0;
    step;
`ifdef INGEST_PROTO_CHECK_EN
    exp_perr = 1;
`endif
    chk("stray_ready", ready, 1);
    chk("stray_label", image_label, last_label);
    chk("stray_va", valid_all, 0);
    chk("stray_perr", proto_err, exp_perr);
    load(1, 0, 50, 0);
    sweep;
    chk("restart_perr", proto_err, exp_perr);
    finish_image(8'h99);
    load(0, 1, 0, 0);
    sweep;
    finish_image(8'h21);
    load(2, 0, 0, 100);
    load(2, 0, 0, 0);
    sweep;
    chk("abort_perr", proto_err, exp_perr);
    finish_image(8'h3C);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
